// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: self-test sequencer for the 5-switch programmable gate unit.
// Steps the unit through all 32 select/input vectors, samples its result after a
// settle interval, and reports the measured truth table against the golden one.
// Optional build macro: GATE_SWEEP_HALT_ON_ERR_EN (stop on the first mismatch and
// hold the failing vector until start is pulsed again).
module gate_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        result_in,
    output logic [4:0]  sw_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  err_count,
    output logic [4:0]  first_fail,
    output logic [31:0] truth_table
);

    // Expected unit result for each vector; nibble k holds opcode k, bit j is {b,a}=j.
    localparam logic [31:0] GOLDEN = 32'h781E_69A5;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [4:0] LAST_IDX = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SAMPLE = 3'd2,
`ifdef GATE_SWEEP_HALT_ON_ERR_EN
        S_HALT   = 3'd4,
`endif
        S_DONE   = 3'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [4:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;

    // The vector under test is the sweep index itself; it is held between sweeps.
    assign sw_out = idx;

    // Compare the unit's current result against the golden entry for this vector.
    always_comb begin
        mismatch = (result_in != GOLDEN[idx]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the sweep sequence.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt == SETTLE_LAST) begin
                    next_state = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
`ifdef GATE_SWEEP_HALT_ON_ERR_EN
                if (mismatch) begin
                    next_state = S_HALT;
                end else if (idx == LAST_IDX) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_DRIVE;
                end
`else
                if (idx == LAST_IDX) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_DRIVE;
                end
`endif
            end
`ifdef GATE_SWEEP_HALT_ON_ERR_EN
            S_HALT: begin
                if (start) begin
                    next_state = S_DONE;
                end
            end
`endif
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs: busy covers every state except IDLE.
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Sweep datapath: index, settle counter, result capture and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            first_fail  <= '0;
            truth_table <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx         <= '0;
                        cnt         <= '0;
                        pass        <= 1'b0;
                        err_count   <= '0;
                        first_fail  <= '0;
                        truth_table <= '0;
                    end
                end
                S_DRIVE: begin
                    cnt <= cnt + CNT_W'(1);
                end
                S_SAMPLE: begin
                    truth_table[idx] <= result_in;
                    if (mismatch) begin
                        err_count <= err_count + 6'd1;
                        if (err_count == 6'd0) begin
                            first_fail <= idx;
                        end
                    end
                    // Advance only when another vector follows; idx never wraps.
                    if (next_state == S_DRIVE) begin
                        idx <= idx + 5'd1;
                        cnt <= '0;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    pass <= (err_count == 6'd0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: scoreboard bench for gate_sweep_ctrl with a behavioural gate
// unit (selectable faults and DRIVE-time glitches) and a sweep-level reference model.
module tb_gate_sweep_ctrl;

    localparam int SETTLE = 2;
    localparam int SWEEP_LAT = 1 + 32 * (SETTLE + 1) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        result_in;
    logic [4:0]  sw_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [5:0]  err_count;
    logic [4:0]  first_fail;
    logic [31:0] truth_table;

    gate_sweep_ctrl #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .result_in   (result_in),
        .sw_out      (sw_out),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_count   (err_count),
        .first_fail  (first_fail),
        .truth_table (truth_table)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ideal gate behaviour from the opcode table.
    function automatic logic gate_ref(input logic [2:0] op, input logic b, input logic a);
        case (op)
            3'd0: return ~a;
            3'd1: return a;
            3'd2: return ~(a ^ b);
            3'd3: return a ^ b;
            3'd4: return a | b;
            3'd5: return ~(a | b);
            3'd6: return a & b;
            default: return ~(a & b);
        endcase
    endfunction

    // Gate unit under various fault modes:
    // 0 good, 1 AND behaves as OR, 2 stuck at 0, 3 NOR inverted, 4 random per-vector flips.
    function automatic logic unit_out(input int mode, input logic [31:0] rmask, input logic [4:0] v);
        logic good;
        good = gate_ref(v[4:2], v[1], v[0]);
        case (mode)
            1: return (v[4:2] == 3'd6) ? (v[1] | v[0]) : good;
            2: return 1'b0;
            3: return (v[4:2] == 3'd5) ? ~good : good;
            4: return good ^ rmask[v];
            default: return good;
        endcase
    endfunction

    int          mode;
    logic [31:0] rmask;
    logic        glitch_en;
    logic [4:0]  prev_sw;

    always @(posedge clk) prev_sw <= sw_out;

    // Unit output, inverted for the first cycle after each vector change when glitching.
    always_comb begin
        result_in = unit_out(mode, rmask, sw_out) ^ (glitch_en && (sw_out != prev_sw));
    end

    typedef struct {
        logic [31:0] tt;
        logic [5:0]  err;
        logic [4:0]  ff;
        logic        pass;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t sbq[$];

    // Sweep-level reference: what the sequencer must report for a given unit behaviour.
    function automatic exp_t predict(input int m, input logic [31:0] rm);
        exp_t e;
        int   errs;
        bit   halted;
        logic meas;
        logic gold;
        logic [4:0] v;
        e.tt = '0;
        e.ff = '0;
        errs = 0;
        halted = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (!halted) begin
                v    = 5'(i);
                meas = unit_out(m, rm, v);
                gold = gate_ref(v[4:2], v[1], v[0]);
                e.tt[i] = meas;
                if (meas != gold) begin
                    if (errs == 0) e.ff = v;
                    errs++;
`ifdef GATE_SWEEP_HALT_ON_ERR_EN
                    halted = 1'b1;
`endif
                end
            end
        end
        e.err  = 6'(errs);
        e.pass = (errs == 0);
        e.lat  = halted ? -1 : SWEEP_LAT;
        e.start_cyc = 0;
        return e;
    endfunction

    // Monitor: every done pulse pops the oldest expectation and compares.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no pending sweep");
            end else begin
                e = sbq.pop_front();
                check("truth_table", truth_table, e.tt);
                check("err_count", 32'(err_count), 32'(e.err));
                check("first_fail", 32'(first_fail), 32'(e.ff));
                check("pass", 32'(pass), 32'(e.pass));
                check("busy_at_done", 32'(busy), 32'd0);
                if (e.lat >= 0) check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            end
        end
    end

    // Runs one sweep; optional extra start pulses, and an abort by reset at vector abort_idx.
    task automatic run_sweep(input int m, input logic [31:0] rm, input logic ge,
                             input bit extra, input int abort_idx);
        exp_t e;
        int   k;
        int   bad_seq;
        bit   seen;
        mode      = m;
        rmask     = rm;
        glitch_en = ge;
        e = predict(m, rm);
        @(negedge clk);
        e.start_cyc = cyc;
        if (abort_idx < 0) sbq.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        k       = 1;
        seen    = 1'b0;
        bad_seq = 0;
        while (!seen && k < 400) begin
            start = extra && (k == 10 || k == 50);
            if (extra && k <= 96 && sw_out !== 5'((k - 1) / 3)) bad_seq++;
            if (abort_idx >= 0 && k == 3 * abort_idx + 2) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_sw_out", 32'(sw_out), 32'd0);
                check("abort_err_count", 32'(err_count), 32'd0);
                check("abort_truth_table", truth_table, 32'd0);
                check("abort_pass", 32'(pass), 32'd0);
                return;
            end
`ifdef GATE_SWEEP_HALT_ON_ERR_EN
            if (e.lat < 0 && k == 3 * (32'(e.ff) + 1) + 6) begin
                check("halt_sw_out", 32'(sw_out), 32'(e.ff));
                check("halt_busy", 32'(busy), 32'd1);
                check("halt_err_count", 32'(err_count), 32'd1);
                check("halt_first_fail", 32'(first_fail), 32'(e.ff));
                start = 1'b1;
            end
`endif
            if (done === 1'b1) seen = 1'b1;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL sweep_timeout: got no done in %0d cycles, expected done", k);
            if (abort_idx < 0 && sbq.size() > 0) void'(sbq.pop_back());
        end else begin
            check("done_one_cycle", 32'(done), 32'd0);
            check("busy_after_done", 32'(busy), 32'd0);
            if (extra) check("sw_out_sequence_errors", 32'(bad_seq), 32'd0);
        end
    endtask

`ifdef GATE_SWEEP_HALT_ON_ERR_EN
    localparam int AND_OR_ERR = 1;
    localparam int STUCK_ERR  = 1;
    localparam int NOR_ERR    = 1;
`else
    localparam int AND_OR_ERR = 2;
    localparam int STUCK_ERR  = 16;
    localparam int NOR_ERR    = 4;
`endif

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] rm;
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 0;
        rmask     = '0;
        glitch_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pass", 32'(pass), 32'd0);
        check("reset_err_count", 32'(err_count), 32'd0);
        check("reset_first_fail", 32'(first_fail), 32'd0);
        check("reset_truth_table", truth_table, 32'd0);
        check("reset_sw_out", 32'(sw_out), 32'd0);
        rst = 1'b0;

        // Good unit.
        run_sweep(0, '0, 1'b0, 1'b0, -1);
        check("golden_table", truth_table, 32'h781E_69A5);
        check("golden_pass", 32'(pass), 32'd1);

        // AND replaced by OR.
        run_sweep(1, '0, 1'b0, 1'b0, -1);
        check("and_or_err", 32'(err_count), 32'(AND_OR_ERR));
        check("and_or_first_fail", 32'(first_fail), 32'd25);

        // Output stuck at 0.
        run_sweep(2, '0, 1'b0, 1'b0, -1);
        check("stuck_err", 32'(err_count), 32'(STUCK_ERR));
        check("stuck_first_fail", 32'(first_fail), 32'd0);

        // Extra starts mid-sweep plus glitches during DRIVE.
        run_sweep(0, '0, 1'b1, 1'b1, -1);

        // Reset while vector 12 is driven, then a clean sweep.
        run_sweep(0, '0, 1'b0, 1'b0, 12);
        run_sweep(0, '0, 1'b0, 1'b0, -1);

        // NOR inverted.
        run_sweep(3, '0, 1'b0, 1'b0, -1);
        check("nor_err", 32'(err_count), 32'(NOR_ERR));
        check("nor_first_fail", 32'(first_fail), 32'd20);

        // Random sparse fault masks, random glitching.
        for (int r = 0; r < 6; r++) begin
            rm = $urandom & $urandom & $urandom;
            if (r == 0) rm = 32'h8000_0000;
            run_sweep(4, rm, 1'($urandom_range(0, 1)), 1'b0, -1);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
